// File: rtl/milano_pkg.sv
// milano_pkg
// Shared LSU types and helpers.
//   lsu_opt_e      : memory operation selector presented by the execute stage
//   lsu_misaligned : 1 when the operation cannot be issued at the given byte offset
//   lsu_is_store   : 1 for SB/SH/SW
package milano_pkg;

  typedef enum logic [3:0] {
    LSU_NONE = 4'd0,
    LSU_LB   = 4'd1,
    LSU_LH   = 4'd2,
    LSU_LW   = 4'd3,
    LSU_LBU  = 4'd4,
    LSU_LHU  = 4'd5,
    LSU_SB   = 4'd6,
    LSU_SH   = 4'd7,
    LSU_SW   = 4'd8
  } lsu_opt_e;

  function automatic logic lsu_misaligned(input lsu_opt_e opt, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (opt)
      LSU_LW, LSU_SW:          mis = (addr_lo != 2'b00);
      LSU_LH, LSU_LHU, LSU_SH: mis = addr_lo[0];
      default:                 mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic lsu_is_store(input lsu_opt_e opt);
    return (opt == LSU_SB) || (opt == LSU_SH) || (opt == LSU_SW);
  endfunction

endpackage

// File: rtl/milano_lsu_load_align.sv
// milano_lsu_load_align
// Combinational lane select and extension of a memory read word.
//   i_opt     : load operation (LB/LH/LBU/LHU/LW; anything else passes the word)
//   i_addr_lo : byte offset within the word
//   i_rdata   : raw memory word
//   o_data    : aligned, extended load result
module milano_lsu_load_align
  import milano_pkg::*;
(
  input  lsu_opt_e    i_opt,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_data = i_rdata;
    case (i_opt)
      LSU_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      LSU_LBU: o_data = {24'h0, w_byte};
      LSU_LH:  o_data = {{16{w_half[15]}}, w_half};
      LSU_LHU: o_data = {16'h0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/milano_lsu.sv
// milano_lsu
// Load/store unit between the execute stage and a req/gnt/rvalid data port.
//   clk_i, rst_ni               : clock, async active-low reset
//   lsu_req_i/opt/addr/wdata    : operation from execute stage
//   lsu_ready_o                 : 1 when a new operation can be taken
//   lsu_rvalid_o/rdata_o/err_o  : completion pulse, load result, misalignment pulse
//   data_req_o/gnt_i            : memory request handshake
//   data_addr/we/be/wdata_o     : word-aligned request payload
//   data_rvalid_i/rdata_i       : memory response
//
// state       | meaning
// IDLE        | ready for a new operation
// WAIT_GNT    | request on the bus, waiting for grant
// WAIT_RVALID | granted, waiting for the memory response
// ERR         | misaligned access, one-cycle error pulse
module milano_lsu
  import milano_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_req_i,
  input  lsu_opt_e    lsu_opt_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_ready_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2,
    ERR         = 2'd3
  } state_e;

  state_e      r_state, w_state_nxt;
  lsu_opt_e    r_opt;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_we;
  logic        r_rvalid;
  logic [31:0] r_rdata;

  logic        w_accept;
  logic        w_resp;
  logic [3:0]  w_fmt_be;
  logic [31:0] w_fmt_wdata;
  logic [31:0] w_load_data;

  assign w_accept = lsu_req_i && lsu_ready_o && (lsu_opt_i != LSU_NONE);
  // Responses outside WAIT_RVALID (e.g. a late one after reset) are dropped.
  assign w_resp   = (r_state == WAIT_RVALID) && data_rvalid_i;

  always_comb begin
    w_fmt_be    = 4'b1111;
    w_fmt_wdata = lsu_wdata_i;
    case (lsu_opt_i)
      LSU_SB: begin
        w_fmt_be    = 4'b0001 << lsu_addr_i[1:0];
        w_fmt_wdata = {4{lsu_wdata_i[7:0]}};
      end
      LSU_SH: begin
        w_fmt_be    = 4'b0011 << lsu_addr_i[1:0];
        w_fmt_wdata = {2{lsu_wdata_i[15:0]}};
      end
      default: begin
        w_fmt_be    = 4'b1111;
        w_fmt_wdata = lsu_wdata_i;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    lsu_ready_o  = 1'b0;
    data_req_o   = 1'b0;
    lsu_err_o    = 1'b0;
    case (r_state)
      IDLE: begin
        lsu_ready_o = 1'b1;
        if (w_accept)
          w_state_nxt = lsu_misaligned(lsu_opt_i, lsu_addr_i[1:0]) ? ERR : WAIT_GNT;
      end
      WAIT_GNT: begin
        data_req_o = 1'b1;
        if (data_gnt_i) w_state_nxt = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (data_rvalid_i) w_state_nxt = IDLE;
      end
      ERR: begin
        lsu_err_o   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_opt     <= LSU_NONE;
      r_addr_lo <= 2'b00;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      r_be      <= 4'h0;
      r_we      <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'h0;
    end else begin
      if (w_accept) begin
        r_opt     <= lsu_opt_i;
        r_addr_lo <= lsu_addr_i[1:0];
        r_addr    <= {lsu_addr_i[31:2], 2'b00};
        r_wdata   <= w_fmt_wdata;
        r_be      <= w_fmt_be;
        r_we      <= lsu_is_store(lsu_opt_i);
      end
      r_rvalid <= w_resp;
      if (w_resp)
        r_rdata <= lsu_is_store(r_opt) ? 32'h0 : w_load_data;
    end
  end

  milano_lsu_load_align u_load_align (
    .i_opt     (r_opt),
    .i_addr_lo (r_addr_lo),
    .i_rdata   (data_rdata_i),
    .o_data    (w_load_data)
  );

  assign lsu_rvalid_o = r_rvalid;
  assign lsu_rdata_o  = r_rdata;
  assign data_addr_o  = r_addr;
  assign data_we_o    = r_we;
  assign data_be_o    = r_be;
  assign data_wdata_o = r_wdata;

endmodule

// File: tb/tb_milano_lsu.sv
module tb_milano_lsu;
  import milano_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        lsu_req_i;
  lsu_opt_e    lsu_opt_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_ready_o;
  logic        lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        lsu_err_o;
  logic        data_req_o;
  logic        data_gnt_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;

  int n_cmp = 0;
  int n_bad = 0;

  milano_lsu dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .lsu_req_i     (lsu_req_i),
    .lsu_opt_i     (lsu_opt_i),
    .lsu_addr_i    (lsu_addr_i),
    .lsu_wdata_i   (lsu_wdata_i),
    .lsu_ready_o   (lsu_ready_o),
    .lsu_rvalid_o  (lsu_rvalid_o),
    .lsu_rdata_o   (lsu_rdata_o),
    .lsu_err_o     (lsu_err_o),
    .data_req_o    (data_req_o),
    .data_gnt_i    (data_gnt_i),
    .data_addr_o   (data_addr_o),
    .data_we_o     (data_we_o),
    .data_be_o     (data_be_o),
    .data_wdata_o  (data_wdata_o),
    .data_rvalid_i (data_rvalid_i),
    .data_rdata_i  (data_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // Runs one complete access; inputs are driven on falling edges. Returns the
  // request payload seen during WAIT_GNT and the completion seen afterwards.
  task automatic run_access(
    input  lsu_opt_e    opt,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  int          gnt_wait,
    input  logic [31:0] mem_rdata,
    output logic        req_held,
    output logic [31:0] o_addr,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_we,
    output logic        o_rvalid,
    output logic [31:0] o_rdata
  );
    @(negedge clk_i);
    lsu_req_i = 1'b1; lsu_opt_i = opt; lsu_addr_i = addr; lsu_wdata_i = wdata;
    @(negedge clk_i);
    lsu_req_i = 1'b0; lsu_opt_i = LSU_NONE;
    req_held = data_req_o;
    o_addr = data_addr_o; o_be = data_be_o; o_wdata = data_wdata_o; o_we = data_we_o;
    for (int i = 0; i < gnt_wait; i++) begin
      @(negedge clk_i);
      req_held = req_held && data_req_o && (data_addr_o == o_addr) && (data_be_o == o_be)
                 && (data_wdata_o == o_wdata) && (data_we_o == o_we);
    end
    data_gnt_i = 1'b1;
    @(negedge clk_i);
    data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = mem_rdata;
    @(negedge clk_i);
    data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
    o_rvalid = lsu_rvalid_o; o_rdata = lsu_rdata_o;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    n_cmp++; if (lsu_ready_o !== 1'b1)   begin n_bad++; $display("FAIL rst_ready: got %b want 1", lsu_ready_o); end
    n_cmp++; if (data_req_o !== 1'b0)    begin n_bad++; $display("FAIL rst_req: got %b want 0", data_req_o); end
    n_cmp++; if (data_we_o !== 1'b0)     begin n_bad++; $display("FAIL rst_we: got %b want 0", data_we_o); end
    n_cmp++; if (lsu_rvalid_o !== 1'b0)  begin n_bad++; $display("FAIL rst_rvalid: got %b want 0", lsu_rvalid_o); end
    n_cmp++; if (lsu_err_o !== 1'b0)     begin n_bad++; $display("FAIL rst_err: got %b want 0", lsu_err_o); end
    n_cmp++; if (data_be_o !== 4'h0)     begin n_bad++; $display("FAIL rst_be: got %h want 0", data_be_o); end
    n_cmp++; if (data_addr_o !== 32'h0)  begin n_bad++; $display("FAIL rst_addr: got %h want 0", data_addr_o); end
    n_cmp++; if (data_wdata_o !== 32'h0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", data_wdata_o); end
    n_cmp++; if (lsu_rdata_o !== 32'h0)  begin n_bad++; $display("FAIL rst_rdata: got %h want 0", lsu_rdata_o); end
    rst_ni = 1'b1;
  endtask

  task automatic test_lw();
    logic held, we, rv; logic [31:0] a, wd, rd; logic [3:0] be;
    run_access(LSU_LW, 32'h100, 32'h0, 2, 32'hDEADBEEF, held, a, be, wd, we, rv, rd);
    n_cmp++; if (held !== 1'b1)       begin n_bad++; $display("FAIL lw_req_held: got %b want 1", held); end
    n_cmp++; if (a !== 32'h100)       begin n_bad++; $display("FAIL lw_addr: got %h want 00000100", a); end
    n_cmp++; if (be !== 4'b1111)      begin n_bad++; $display("FAIL lw_be: got %b want 1111", be); end
    n_cmp++; if (we !== 1'b0)         begin n_bad++; $display("FAIL lw_we: got %b want 0", we); end
    n_cmp++; if (rv !== 1'b1)         begin n_bad++; $display("FAIL lw_rvalid: got %b want 1", rv); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_rdata: got %h want deadbeef", rd); end
    @(negedge clk_i);
    n_cmp++; if (lsu_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL lw_rvalid_pulse: got %b want 0", lsu_rvalid_o); end
  endtask

  task automatic test_load_ext();
    lsu_opt_e    opts [6] = '{LSU_LB, LSU_LBU, LSU_LHU, LSU_LH, LSU_LB, LSU_LH};
    logic [31:0] addrs[6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h100};
    logic [31:0] exps [6] = '{32'hFFFFFF80, 32'h00000080, 32'h00008012, 32'hFFFF8012,
                              32'h00000034, 32'h00003456};
    logic held, we, rv; logic [31:0] a, wd, rd; logic [3:0] be;
    for (int i = 0; i < 6; i++) begin
      run_access(opts[i], addrs[i], 32'h0, 0, 32'h80123456, held, a, be, wd, we, rv, rd);
      n_cmp++; if (rv !== 1'b1)    begin n_bad++; $display("FAIL ld%0d_rvalid: got %b want 1", i, rv); end
      n_cmp++; if (rd !== exps[i]) begin n_bad++; $display("FAIL ld%0d_rdata: got %h want %h", i, rd, exps[i]); end
      n_cmp++; if (a !== 32'h100)  begin n_bad++; $display("FAIL ld%0d_addr: got %h want 00000100", i, a); end
    end
  endtask

  task automatic test_store();
    lsu_opt_e    opts [3] = '{LSU_SH, LSU_SB, LSU_SW};
    logic [31:0] addrs[3] = '{32'h206, 32'h301, 32'h40C};
    logic [31:0] wdin [3] = '{32'h1234ABCD, 32'h000000A5, 32'hCAFEF00D};
    logic [31:0] ea   [3] = '{32'h204, 32'h300, 32'h40C};
    logic [3:0]  ebe  [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] ewd  [3] = '{32'hABCDABCD, 32'hA5A5A5A5, 32'hCAFEF00D};
    logic held, we, rv; logic [31:0] a, wd, rd; logic [3:0] be;
    for (int i = 0; i < 3; i++) begin
      run_access(opts[i], addrs[i], wdin[i], 1, 32'hFFFFFFFF, held, a, be, wd, we, rv, rd);
      n_cmp++; if (held !== 1'b1)  begin n_bad++; $display("FAIL st%0d_req_held: got %b want 1", i, held); end
      n_cmp++; if (a !== ea[i])    begin n_bad++; $display("FAIL st%0d_addr: got %h want %h", i, a, ea[i]); end
      n_cmp++; if (be !== ebe[i])  begin n_bad++; $display("FAIL st%0d_be: got %b want %b", i, be, ebe[i]); end
      n_cmp++; if (wd !== ewd[i])  begin n_bad++; $display("FAIL st%0d_wdata: got %h want %h", i, wd, ewd[i]); end
      n_cmp++; if (we !== 1'b1)    begin n_bad++; $display("FAIL st%0d_we: got %b want 1", i, we); end
      n_cmp++; if (rv !== 1'b1)    begin n_bad++; $display("FAIL st%0d_rvalid: got %b want 1", i, rv); end
      n_cmp++; if (rd !== 32'h0)   begin n_bad++; $display("FAIL st%0d_rdata: got %h want 0", i, rd); end
    end
  endtask

  task automatic test_misaligned();
    lsu_opt_e    opts [3] = '{LSU_LW, LSU_SH, LSU_LHU};
    logic [31:0] addrs[3] = '{32'h101, 32'h203, 32'h301};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      lsu_req_i = 1'b1; lsu_opt_i = opts[i]; lsu_addr_i = addrs[i]; lsu_wdata_i = 32'h55;
      @(negedge clk_i);
      lsu_req_i = 1'b0; lsu_opt_i = LSU_NONE;
      data_rvalid_i = 1'b1; data_rdata_i = 32'h12345678;
      n_cmp++; if (lsu_err_o !== 1'b1)    begin n_bad++; $display("FAIL mis%0d_err: got %b want 1", i, lsu_err_o); end
      n_cmp++; if (data_req_o !== 1'b0)   begin n_bad++; $display("FAIL mis%0d_req: got %b want 0", i, data_req_o); end
      n_cmp++; if (lsu_ready_o !== 1'b0)  begin n_bad++; $display("FAIL mis%0d_ready: got %b want 0", i, lsu_ready_o); end
      @(negedge clk_i);
      data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
      n_cmp++; if (lsu_err_o !== 1'b0)    begin n_bad++; $display("FAIL mis%0d_err_pulse: got %b want 0", i, lsu_err_o); end
      n_cmp++; if (lsu_ready_o !== 1'b1)  begin n_bad++; $display("FAIL mis%0d_ready_back: got %b want 1", i, lsu_ready_o); end
      n_cmp++; if (data_req_o !== 1'b0)   begin n_bad++; $display("FAIL mis%0d_req_after: got %b want 0", i, data_req_o); end
      n_cmp++; if (lsu_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL mis%0d_rvalid: got %b want 0", i, lsu_rvalid_o); end
    end
  endtask

  task automatic test_none();
    @(negedge clk_i);
    lsu_req_i = 1'b1; lsu_opt_i = LSU_NONE; lsu_addr_i = 32'h101;
    @(negedge clk_i);
    n_cmp++; if (lsu_ready_o !== 1'b1) begin n_bad++; $display("FAIL none_ready: got %b want 1", lsu_ready_o); end
    n_cmp++; if (data_req_o !== 1'b0)  begin n_bad++; $display("FAIL none_req: got %b want 0", data_req_o); end
    n_cmp++; if (lsu_err_o !== 1'b0)   begin n_bad++; $display("FAIL none_err: got %b want 0", lsu_err_o); end
    lsu_req_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i);
    lsu_req_i = 1'b1; lsu_opt_i = LSU_LW; lsu_addr_i = 32'h100;
    @(negedge clk_i);
    lsu_req_i = 1'b0; lsu_opt_i = LSU_NONE; data_gnt_i = 1'b1;
    @(negedge clk_i);
    data_gnt_i = 1'b0;
    n_cmp++; if (lsu_ready_o !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", lsu_ready_o); end
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (lsu_ready_o !== 1'b1) begin n_bad++; $display("FAIL rmid_ready_async: got %b want 1", lsu_ready_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    data_rvalid_i = 1'b1; data_rdata_i = 32'hDEADBEEF;
    @(negedge clk_i);
    data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
    n_cmp++; if (lsu_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL rmid_rvalid: got %b want 0", lsu_rvalid_o); end
    n_cmp++; if (lsu_ready_o !== 1'b1)  begin n_bad++; $display("FAIL rmid_ready: got %b want 1", lsu_ready_o); end
    n_cmp++; if (lsu_rdata_o !== 32'h0) begin n_bad++; $display("FAIL rmid_rdata: got %h want 0", lsu_rdata_o); end
    n_cmp++; if (data_req_o !== 1'b0)   begin n_bad++; $display("FAIL rmid_req: got %b want 0", data_req_o); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i);
    lsu_req_i = 1'b1; lsu_opt_i = LSU_SW; lsu_addr_i = 32'h500; lsu_wdata_i = 32'h11111111;
    @(negedge clk_i);
    lsu_req_i = 1'b0; lsu_opt_i = LSU_NONE; data_gnt_i = 1'b1;
    n_cmp++; if (data_req_o !== 1'b1) begin n_bad++; $display("FAIL b2b_req1: got %b want 1", data_req_o); end
    @(negedge clk_i);
    data_gnt_i = 1'b0; data_rvalid_i = 1'b1;
    @(negedge clk_i);
    data_rvalid_i = 1'b0;
    n_cmp++; if (lsu_rvalid_o !== 1'b1) begin n_bad++; $display("FAIL b2b_rvalid1: got %b want 1", lsu_rvalid_o); end
    n_cmp++; if (lsu_ready_o !== 1'b1)  begin n_bad++; $display("FAIL b2b_ready: got %b want 1", lsu_ready_o); end
    lsu_req_i = 1'b1; lsu_opt_i = LSU_SW; lsu_addr_i = 32'h504; lsu_wdata_i = 32'h22222222;
    @(negedge clk_i);
    lsu_req_i = 1'b0; lsu_opt_i = LSU_NONE; data_gnt_i = 1'b1;
    n_cmp++; if (data_req_o !== 1'b1)         begin n_bad++; $display("FAIL b2b_req2: got %b want 1", data_req_o); end
    n_cmp++; if (data_addr_o !== 32'h504)     begin n_bad++; $display("FAIL b2b_addr2: got %h want 00000504", data_addr_o); end
    n_cmp++; if (data_wdata_o !== 32'h22222222) begin n_bad++; $display("FAIL b2b_wdata2: got %h want 22222222", data_wdata_o); end
    n_cmp++; if (lsu_rvalid_o !== 1'b0)       begin n_bad++; $display("FAIL b2b_rvalid_drop: got %b want 0", lsu_rvalid_o); end
    @(negedge clk_i);
    data_gnt_i = 1'b0; data_rvalid_i = 1'b1;
    @(negedge clk_i);
    data_rvalid_i = 1'b0;
    n_cmp++; if (lsu_rvalid_o !== 1'b1) begin n_bad++; $display("FAIL b2b_rvalid2: got %b want 1", lsu_rvalid_o); end
    n_cmp++; if (lsu_rdata_o !== 32'h0) begin n_bad++; $display("FAIL b2b_rdata2: got %h want 0", lsu_rdata_o); end
  endtask

  initial begin
    rst_ni        = 1'b0;
    lsu_req_i     = 1'b0;
    lsu_opt_i     = LSU_NONE;
    lsu_addr_i    = 32'h0;
    lsu_wdata_i   = 32'h0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_rdata_i  = 32'h0;

    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_misaligned();
    test_none();
    test_reset_mid();
    test_back_to_back();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
